mid_pool_rd: RTL and testbench
==============================

# mid_pool_rd

Read-side controller for the four-bank row buffer that stores convolution results three channels wide (a, b, c). On each row-pair-complete pulse it reads the two just-finished rows from the correct bank pair. It applies signed 2x2 stride-2 max pooling per channel and streams one pooled pixel per two columns to the next layer. It drives the buffer's rden/rd_addr lines and consumes its q outputs.

## Interface
- `image_width`, 11'd28: pixels per row; must be even.
- `image_height`, 11'd28: rows per frame; must be even.
- `ADDR_BASE`, 11'd1: buffer address of column 0; column x is at `ADDR_BASE + x`.
- `RD_LAT`, 1: cycles from rd_addr/rden driven to q valid (1..3).
- clk  in  1  sole clock, all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  enable; low = synchronous abort/clear.
- fin_rd  in  1  one-cycle pulse: a row pair is complete in the buffer.
- bram_toggle  in  1  bank-pair indicator; the buffer updates it on the edge that samples fin_rd.
- qa_0..qa_3, qb_0..qb_3, qc_0..qc_3  in  21 each  bank read data, two's complement.
- in0_rden, in1_rden, in2_rden, in3_rden  out  1 each  bank read enables.
- rd_addr  out  11  shared read address.
- pa, pb, pc  out  21 each  pooled pixel per channel, signed.
- de_out  out  1  pa/pb/pc valid.
- frame_done  out  1  pulse with the last pooled pixel of a frame.
- ovf  out  1  sticky: fin_rd arrived while reading.

## Operation
- States: IDLE, LATCH, READ.
- IDLE -> LATCH on fin_rd=1 with start=1.
- LATCH (1 cycle): sample bram_toggle. 1 selects pair {bank0 top, bank1 bottom}; 0 selects {bank2 top, bank3 bottom}.
- READ: col counter runs 0..image_width-1. rd_addr = ADDR_BASE+col; rden=1 on the selected pair only, 0 on the others. After col = image_width-1, go to IDLE.
- Pipeline, per channel, signed compare: valid tags are delayed RD_LAT cycles. Stage V registers max(top_q, bottom_q). Stage H holds the even-column V result; on the odd column it registers max(hold, V) into pa/pb/pc and pulses de_out.
- On ties, either operand is correct (values equal). No arithmetic widening; 21-bit in, 21-bit out.
- A pair counter counts pooled row pairs 0..image_height/2-1. frame_done is high with the de_out of the last column of the last pair, then the counter wraps to 0.
- fin_rd in LATCH or READ: ignored, ovf<=1. ovf is cleared only by RESET or start=0.
- fin_rd while the pipeline drains in IDLE is accepted. Pipeline stages are independent of the FSM.
- start=0: next edge forces IDLE, rden=0, pipeline valids cleared, pair counter=0, ovf=0. de_out is 0 from the following cycle.
- RESET: all state cleared asynchronously. Outputs pa/pb/pc=0, de_out=0, frame_done=0, ovf=0, all rden=0, rd_addr=0.

## Timing
- Cycle 0: edge samples fin_rd=1. Cycle 1: LATCH. Cycles 2..image_width+1: READ, addresses consecutive, one per cycle, no gaps.
- q for the address in cycle n is used in cycle n+RD_LAT.
- First de_out is in cycle 5+RD_LAT. Then one de_out every 2 cycles, image_width/2 pulses per pair.
- RD_LAT=1, width 28: de_out in cycles 6,8,...,32.
- rd_addr holds its last value in IDLE. rden is 0 in IDLE and LATCH.
- Earliest accepted back-to-back fin_rd is cycle image_width+2. The buffer delivers pairs at least 2*image_width cycles apart.

## Test plan
- Reset: assert RESET mid-READ -> all rden=0, de_out=0, ovf=0 immediately (no clock edge needed); after release, FSM is in IDLE.
- Pair select: bram_toggle=1, banks 0/1 preloaded with a=col, b=-col, c=100 -> in0/in1_rden high for 28 cycles with rd_addr 1..28. 14 outputs: pa=1,3,..,27; pb=0,-2,..,-26; pc=100. in2/in3_rden stay 0.
- Signed max: top=-5, bottom=-3 at col 0 and top=-7, bottom=-4 at col 1 -> pa=-3. Then top=0x100000 (most negative), bottom=0 -> 0.
- Frame: 14 fin_rd pulses spaced 56 cycles, toggle alternating -> 196 de_out. frame_done exactly once, with the 196th; the 15th pair restarts the count.
- Overrun: second fin_rd 10 cycles after the first -> ignored, ovf=1 and stays 1, output count unaffected. Then start=0 -> ovf=0.
- RD_LAT=3 build: same stimulus as pair select -> identical data, first de_out in cycle 8.

Source files
------------

// File: rtl/mid_pool_rd.sv
// mid_pool_rd: read-side controller for the four-bank row buffer.
// On each row-pair pulse it reads both finished rows from the selected bank
// pair and emits signed 2x2 stride-2 max-pooled pixels for channels a/b/c.
module mid_pool_rd #(
  parameter logic [10:0] image_width  = 11'd28,
  parameter logic [10:0] image_height = 11'd28,
  parameter logic [10:0] ADDR_BASE    = 11'd1,
  parameter int          RD_LAT       = 1,
  parameter int          DATA_W       = 21
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     fin_rd,
  input  logic                     bram_toggle,
  input  logic signed [DATA_W-1:0] qa_0,
  input  logic signed [DATA_W-1:0] qa_1,
  input  logic signed [DATA_W-1:0] qa_2,
  input  logic signed [DATA_W-1:0] qa_3,
  input  logic signed [DATA_W-1:0] qb_0,
  input  logic signed [DATA_W-1:0] qb_1,
  input  logic signed [DATA_W-1:0] qb_2,
  input  logic signed [DATA_W-1:0] qb_3,
  input  logic signed [DATA_W-1:0] qc_0,
  input  logic signed [DATA_W-1:0] qc_1,
  input  logic signed [DATA_W-1:0] qc_2,
  input  logic signed [DATA_W-1:0] qc_3,
  output logic                     in0_rden,
  output logic                     in1_rden,
  output logic                     in2_rden,
  output logic                     in3_rden,
  output logic [10:0]              rd_addr,
  output logic signed [DATA_W-1:0] pa,
  output logic signed [DATA_W-1:0] pb,
  output logic signed [DATA_W-1:0] pc,
  output logic                     de_out,
  output logic                     frame_done,
  output logic                     ovf
);

  localparam logic [10:0] LAST_COL  = image_width - 11'd1;
  localparam logic [10:0] LAST_PAIR = (image_height >> 1) - 11'd1;

  typedef enum logic [1:0] {IDLE, LATCH, READ} state_t;

  // Tag travelling with each read: {valid, odd column, last column, pair select}
  typedef struct packed {
    logic vld;
    logic odd;
    logic last;
    logic sel;
  } tag_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] col;
  logic        sel;
  logic [3:0]  rden;
  tag_t        tag_dly [RD_LAT];
  tag_t        tag_q;
  logic [10:0] pair_cnt;

  logic signed [DATA_W-1:0] top_a, top_b, top_c;
  logic signed [DATA_W-1:0] bot_a, bot_b, bot_c;

  logic                     vld_p1, odd_p1, last_p1;
  logic signed [DATA_W-1:0] va_p1, vb_p1, vc_p1;
  logic signed [DATA_W-1:0] ha_p2, hb_p2, hc_p2;
  logic                     emit_p1;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    return (x > y) ? x : y;
  endfunction

  assign in0_rden = rden[0];
  assign in1_rden = rden[1];
  assign in2_rden = rden[2];
  assign in3_rden = rden[3];

  // FSM state register; start low aborts to IDLE on the next edge
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)       state <= IDLE;
    else if (!start) state <= IDLE;
    else             state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fin_rd) state_nxt = LATCH;
      LATCH:   state_nxt = READ;
      READ:    if (col == LAST_COL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address/enable generation, bank-pair latch and overrun flag
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      col     <= '0;
      rd_addr <= '0;
      rden    <= '0;
      sel     <= 1'b0;
      ovf     <= 1'b0;
    end else if (!start) begin
      rden <= '0;
      ovf  <= 1'b0;
    end else begin
      if (state == LATCH) begin
        sel     <= bram_toggle;
        col     <= '0;
        rd_addr <= ADDR_BASE;
        rden    <= bram_toggle ? 4'b0011 : 4'b1100;
      end else if (state == READ) begin
        if (col == LAST_COL) begin
          rden <= '0;
        end else begin
          col     <= col + 11'd1;
          rd_addr <= rd_addr + 11'd1;
        end
      end
      if (fin_rd && (state != IDLE)) ovf <= 1'b1;
    end
  end

  // Delay the read tag by RD_LAT cycles so it lines up with q
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < RD_LAT; i++) tag_dly[i] <= '0;
    end else if (!start) begin
      for (int i = 0; i < RD_LAT; i++) tag_dly[i] <= '0;
    end else begin
      tag_dly[0] <= '{vld: |rden, odd: col[0], last: (col == LAST_COL), sel: sel};
      for (int i = 1; i < RD_LAT; i++) tag_dly[i] <= tag_dly[i-1];
    end
  end

  assign tag_q = tag_dly[RD_LAT-1];

  // Top/bottom row selection from the bank pair the tag was read from
  always_comb begin
    top_a = tag_q.sel ? qa_0 : qa_2;
    top_b = tag_q.sel ? qb_0 : qb_2;
    top_c = tag_q.sel ? qc_0 : qc_2;
    bot_a = tag_q.sel ? qa_1 : qa_3;
    bot_b = tag_q.sel ? qb_1 : qb_3;
    bot_c = tag_q.sel ? qc_1 : qc_3;
  end

  // ---- stage V (p1): vertical max of top and bottom rows ----
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vld_p1  <= 1'b0;
      odd_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (!start) begin
      vld_p1  <= 1'b0;
      odd_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= tag_q.vld;
      odd_p1  <= tag_q.odd;
      last_p1 <= tag_q.last;
    end
  end

  // Stage V data path
  always_ff @(posedge clk) begin
    if (tag_q.vld) begin
      va_p1 <= smax(top_a, bot_a);
      vb_p1 <= smax(top_b, bot_b);
      vc_p1 <= smax(top_c, bot_c);
    end
  end

  assign emit_p1 = vld_p1 && odd_p1;

  // ---- stage H (p2): hold even column, combine on odd column ----
  always_ff @(posedge clk) begin
    if (vld_p1 && !odd_p1) begin
      ha_p2 <= va_p1;
      hb_p2 <= vb_p1;
      hc_p2 <= vc_p1;
    end
  end

  // Pooled output registers
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pa <= '0;
      pb <= '0;
      pc <= '0;
    end else if (emit_p1) begin
      pa <= smax(ha_p2, va_p1);
      pb <= smax(hb_p2, vb_p1);
      pc <= smax(hc_p2, vc_p1);
    end
  end

  // Output strobe, frame tracking over pooled row pairs
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      de_out     <= 1'b0;
      frame_done <= 1'b0;
      pair_cnt   <= '0;
    end else if (!start) begin
      de_out     <= 1'b0;
      frame_done <= 1'b0;
      pair_cnt   <= '0;
    end else begin
      de_out     <= emit_p1;
      frame_done <= emit_p1 && last_p1 && (pair_cnt == LAST_PAIR);
      if (emit_p1 && last_p1) begin
        pair_cnt <= (pair_cnt == LAST_PAIR) ? 11'd0 : pair_cnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_mid_pool_rd.sv
// Bench for mid_pool_rd: behavioural buffer model, window-max reference
// model feeding an expectation queue, and a monitor that pops on de_out.
module tb_mid_pool_rd;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int B   = 1;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic RESET, start, fin_rd, bram_toggle;
  logic signed [20:0] qa [4];
  logic signed [20:0] qb [4];
  logic signed [20:0] qc [4];
  logic in0_rden, in1_rden, in2_rden, in3_rden;
  logic [10:0] rd_addr;
  logic signed [20:0] pa, pb, pc;
  logic de_out, frame_done, ovf;
  logic [3:0] rden_v;

  logic signed [20:0] ma [4][64];
  logic signed [20:0] mb [4][64];
  logic signed [20:0] mc [4][64];
  logic signed [20:0] qpa [4][LAT];
  logic signed [20:0] qpb [4][LAT];
  logic signed [20:0] qpc [4][LAT];

  typedef struct {
    int                 cyc;
    logic signed [20:0] a, b, c;
    logic               fd;
  } exp_t;
  exp_t q_exp[$];
  exp_t e;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_f = -1000;
  logic last_sel = 1'b0;
  int pair_m = 0;
  logic ovf_m = 1'b0;
  int n_push = 0;
  int n_de = 0;
  int n_fd = 0;

  mid_pool_rd #(
    .image_width(11'd28), .image_height(11'd28), .ADDR_BASE(11'd1), .RD_LAT(LAT), .DATA_W(21)
  ) dut (
    .clk(clk), .RESET(RESET), .start(start), .fin_rd(fin_rd), .bram_toggle(bram_toggle),
    .qa_0(qa[0]), .qa_1(qa[1]), .qa_2(qa[2]), .qa_3(qa[3]),
    .qb_0(qb[0]), .qb_1(qb[1]), .qb_2(qb[2]), .qb_3(qb[3]),
    .qc_0(qc[0]), .qc_1(qc[1]), .qc_2(qc[2]), .qc_3(qc[3]),
    .in0_rden(in0_rden), .in1_rden(in1_rden), .in2_rden(in2_rden), .in3_rden(in3_rden),
    .rd_addr(rd_addr), .pa(pa), .pb(pb), .pc(pc),
    .de_out(de_out), .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign rden_v = {in3_rden, in2_rden, in1_rden, in0_rden};

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: read data appears LAT cycles after rden/rd_addr
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rden_v[k]) begin
        qpa[k][0] <= ma[k][rd_addr[5:0]];
        qpb[k][0] <= mb[k][rd_addr[5:0]];
        qpc[k][0] <= mc[k][rd_addr[5:0]];
      end
      for (int i = 1; i < LAT; i++) begin
        qpa[k][i] <= qpa[k][i-1];
        qpb[k][i] <= qpb[k][i-1];
        qpc[k][i] <= qpc[k][i-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      qa[k] = qpa[k][LAT-1];
      qb[k] = qpb[k][LAT-1];
      qc[k] = qpc[k][LAT-1];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [20:0] win_max(
    input logic signed [20:0] a0, input logic signed [20:0] a1,
    input logic signed [20:0] a2, input logic signed [20:0] a3);
    logic signed [20:0] m;
    m = a0;
    if (a1 > m) m = a1;
    if (a2 > m) m = a2;
    if (a3 > m) m = a3;
    return m;
  endfunction

  // Reference: each output is the max of a 2x2 window of the two stored rows
  task automatic push_pair(input logic tog, input int f);
    int t, bt, x;
    exp_t n;
    t  = tog ? 0 : 2;
    bt = tog ? 1 : 3;
    for (int j = 0; j < W / 2; j++) begin
      x = B + 2 * j;
      n.cyc = f + 4 + LAT + 2 * j;
      n.a = win_max(ma[t][x], ma[bt][x], ma[t][x+1], ma[bt][x+1]);
      n.b = win_max(mb[t][x], mb[bt][x], mb[t][x+1], mb[bt][x+1]);
      n.c = win_max(mc[t][x], mc[bt][x], mc[t][x+1], mc[bt][x+1]);
      n.fd = (pair_m == H / 2 - 1) && (j == W / 2 - 1);
      q_exp.push_back(n);
      n_push++;
    end
    pair_m = (pair_m + 1) % (H / 2);
  endtask

  task automatic fill_rand(input int top);
    for (int k = top; k < top + 2; k++)
      for (int x = 0; x < 64; x++) begin
        ma[k][x] = 21'($urandom);
        mb[k][x] = 21'($urandom);
        mc[k][x] = 21'($urandom);
      end
  endtask

  // Pulse fin_rd; the buffer flips bram_toggle on the sampling edge
  task automatic fire(input logic tog);
    @(negedge clk);
    fin_rd = 1'b1;
    @(posedge clk);
    #1;
    fin_rd = 1'b0;
    bram_toggle = tog;
    if (start && (cyc >= last_f + W + 2)) begin
      last_f   = cyc;
      last_sel = tog;
      push_pair(tog, cyc);
    end else if (start) begin
      ovf_m = 1'b1;
    end
  endtask

  // Monitor: pops expectations on de_out, checks read port every cycle
  always @(negedge clk) begin
    if (!RESET) begin
      if (de_out) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_de", longint'(de_out), 0);
        end else begin
          e = q_exp.pop_front();
          n_de++;
          if (frame_done) n_fd++;
          chk("de_cycle", cyc, e.cyc);
          chk("pa", longint'(pa), longint'(e.a));
          chk("pb", longint'(pb), longint'(e.b));
          chk("pc", longint'(pc), longint'(e.c));
          chk("frame_done", longint'(frame_done), longint'(e.fd));
        end
      end else begin
        chk("frame_done_idle", longint'(frame_done), 0);
      end
      if (cyc >= last_f + 1 && cyc <= last_f + W) begin
        chk("rden", longint'(rden_v), last_sel ? 3 : 12);
        chk("rd_addr", longint'(rd_addr), B + cyc - last_f - 1);
      end else begin
        chk("rden_idle", longint'(rden_v), 0);
      end
    end
  end

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    fin_rd = 1'b0;
    bram_toggle = 1'b0;
    fill_rand(0);
    fill_rand(2);
    #23;
    chk("rst_rden", longint'(rden_v), 0);
    chk("rst_de_out", longint'(de_out), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_rd_addr", longint'(rd_addr), 0);
    chk("rst_pa", longint'(pa), 0);
    chk("rst_pb", longint'(pb), 0);
    chk("rst_pc", longint'(pc), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    @(negedge clk);
    RESET = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);

    // Pair select: banks 0/1 with a=col, b=-col, c=100
    for (int x = 0; x < W; x++)
      for (int k = 0; k < 2; k++) begin
        ma[k][B+x] = 21'(x);
        mb[k][B+x] = 21'(-x);
        mc[k][B+x] = 21'sd100;
      end
    fire(1'b1);
    repeat (60) @(negedge clk);

    // Signed max corner cases on banks 2/3
    fill_rand(2);
    ma[2][B+0] = -21'sd5;  ma[3][B+0] = -21'sd3;
    ma[2][B+1] = -21'sd7;  ma[3][B+1] = -21'sd4;
    ma[2][B+2] = 21'h100000; ma[3][B+2] = 21'sd0;
    ma[2][B+3] = 21'h100000; ma[3][B+3] = 21'h100000;
    fire(1'b0);
    repeat (60) @(negedge clk);

    // Overrun: second pulse mid-read is ignored and sets ovf
    fill_rand(0);
    fire(1'b1);
    repeat (8) @(negedge clk);
    fire(1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_set", longint'(ovf), longint'(ovf_m));
    repeat (60) @(negedge clk);
    chk("ovf_sticky", longint'(ovf), longint'(ovf_m));
    chk("de_count_overrun", n_de, n_push);
    start = 1'b0;
    ovf_m = 1'b0;
    pair_m = 0;
    @(negedge clk);
    chk("ovf_cleared", longint'(ovf), longint'(ovf_m));
    start = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame plus one pair, alternating bank pairs
    n_fd = 0;
    for (int p = 0; p < 15; p++) begin
      fill_rand((p % 2 == 0) ? 0 : 2);
      fire((p % 2 == 0) ? 1'b1 : 1'b0);
      repeat (54) @(negedge clk);
    end
    chk("frame_done_count", n_fd, (15 / (H / 2)));
    chk("de_count_frame", n_de, n_push);

    // Asynchronous reset in the middle of a read
    fill_rand(0);
    fire(1'b1);
    repeat (5) @(negedge clk);
    #2;
    RESET = 1'b1;
    #1;
    chk("amid_rden", longint'(rden_v), 0);
    chk("amid_de_out", longint'(de_out), 0);
    chk("amid_ovf", longint'(ovf), 0);
    chk("amid_rd_addr", longint'(rd_addr), 0);
    chk("amid_frame_done", longint'(frame_done), 0);
    last_f = -1000;
    q_exp.delete();
    pair_m = 0;
    ovf_m = 1'b0;
    n_de = 0;
    n_push = 0;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    repeat (3) @(negedge clk);

    // Controller returns to IDLE and accepts a fresh pair
    fill_rand(2);
    fire(1'b0);
    repeat (60) @(negedge clk);
    chk("queue_empty", q_exp.size(), 0);
    chk("de_count_final", n_de, n_push);
    chk("ovf_final", longint'(ovf), longint'(ovf_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
